pipe_stall_ctrl: RTL and testbench
==================================

# pipe_stall_ctrl

Central stall and freeze sequencer for the 5-stage pipeline. It sits beside the ID-stage control decoder and drives the write-enable and bubble inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves load-use hazards and handshakes variable-latency data-memory accesses. It also flags a hung memory and counts lost cycles.

## Interface
Parameters:
- TIMEOUT, 16: maximum consecutive WAIT cycles before a memory access is declared hung (≥1).
- CNT_W, 16: width of the stall counter.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- rst, input, 1: synchronous, active-high reset.
- id_opcode, input, 6: opcode of the instruction in ID.
- id_rs, input, 5: rs field of the instruction in ID.
- id_rt, input, 5: rt field of the instruction in ID.
- ex_mem_read, input, 1: MemRead of the instruction in EX (an lw).
- ex_rt, input, 5: destination (rt) of the instruction in EX.
- mem_read, input, 1: MemRead of the instruction in MEM.
- mem_write, input, 1: MemWrite of the instruction in MEM.
- dmem_ready, input, 1: data memory completes the current access this cycle.
- pc_write, output, 1: PC update enable.
- ifid_write, output, 1: IF/ID load enable.
- idex_write, output, 1: ID/EX load enable.
- idex_bubble, output, 1: load zeroed control fields into ID/EX.
- exmem_write, output, 1: EX/MEM load enable.
- memwb_bubble, output, 1: load zeroed control fields into MEM/WB.
- dmem_req, output, 1: data-memory access request.
- err, output, 1: sticky hung-memory flag.
- stall_count, output, CNT_W: count of stalled cycles.

## Operation
Opcode classes:
- R-format 6'b000100 reads rs and rt.
- addiu 6'b001100 and subiu 6'b001101 read rs.
- sw 6'b010000 reads rs and rt.
- lw 6'b010001 reads rs.
- Any other opcode reads nothing.

Load-use hazard (combinational):
- Condition: ex_mem_read=1, ex_rt≠0, and ex_rt matches a register read by the ID instruction.
- Response: pc_write=0, ifid_write=0, idex_bubble=1 for that cycle.
- The condition clears on the next cycle because the bubble has reached EX.

FSM states: RUN, WAIT, ERR. State is RUN after reset. mem_op = mem_read | mem_write.

RUN:
- dmem_req = mem_op.
- If mem_op=1 and dmem_ready=0: full freeze and go to WAIT, wait counter cleared to 0.
- Otherwise all pipeline register enables are 1 (subject to load-use), and the state stays RUN.

WAIT:
- dmem_req=1 and full freeze.
- If dmem_ready=1: freeze lifts that same cycle (enables 1, no memwb_bubble), and the next state is RUN.
- Otherwise the wait counter increments. When it reaches TIMEOUT-1 without ready, go to ERR.

ERR:
- Full freeze, dmem_req=0, err=1.
- ERR is held until rst; no exit on dmem_ready.

Full freeze means pc_write=0, ifid_write=0, idex_write=0, exmem_write=0, memwb_bubble=1. Freeze overrides the load-use response: idex_bubble=0 while frozen, because ID/EX is held.

Stall counter:
- stall_count increments by 1 on every cycle in which pc_write=0 (load-use or freeze, including ERR).
- It saturates at 2^CNT_W−1 and does not wrap.

## Timing
- Reset values, and forced output values while rst=1: state RUN, wait counter 0, err=0, stall_count=0, pc_write=ifid_write=idex_write=exmem_write=1, idex_bubble=0, memwb_bubble=0, dmem_req=0.
- rst has priority over all events, including reset asserted in WAIT or ERR: the next cycle is RUN with the counters cleared.
- Load-use costs exactly 1 cycle of stall.
- A zero-wait access (dmem_ready in the first cycle) costs 0 cycles.
- An access with N wait cycles freezes for exactly N cycles.
- Access with a simultaneous load-use in RUN and dmem_ready=1: the load-use response applies, with no freeze.
- Simultaneous load-use and memory miss: freeze wins. The hazard is re-evaluated when RUN resumes and then costs its 1 bubble.
- ERR entry: after TIMEOUT WAIT cycles without ready, the state is ERR on the following edge and err=1 from that edge on.
- All outputs other than err and stall_count are combinational from state and inputs. err and stall_count are registered.

## Configuration
- STALL_CNT_EN defined: the stall_count register and its saturating increment are implemented as above.
- STALL_CNT_EN undefined: no counter logic is built and stall_count is tied to 0. All other behaviour is identical.

## Test plan
- lw $5 in EX, R-format with rs=5 in ID → one cycle with pc_write=0, ifid_write=0, idex_bubble=1. The next cycle has all enables 1, and stall_count increments by 1.
- lw with ex_rt=0 in EX and addiu with rs=0 in ID → no stall. lw $7 in EX with addiu rt=7 (a written field, not a read field) → no stall.
- sw in MEM, dmem_ready low for 3 cycles then high → 3 freeze cycles with dmem_req=1 and memwb_bubble=1. The release cycle has enables 1, the next state is RUN, and stall_count=3.
- lw in MEM with dmem_ready never asserted and TIMEOUT=16 → 16 WAIT cycles, then ERR with err=1 and dmem_req=0. The state stays ERR after dmem_ready later rises, and rst returns all outputs to the reset values.
- Freeze concurrent with a load-use pair → idex_bubble=0 during the freeze. Exactly 1 bubble follows the return to RUN.
- With STALL_CNT_EN and CNT_W=4, 20 stall cycles → stall_count=15 and held. With the macro undefined, stall_count=0 throughout.

Source files
------------

// File: rtl/pipe_stall_ctrl_if.sv
// Pipeline-side signal bundle of the stall/freeze sequencer. The master modport is the
// sequencer; the slave modport is the pipeline that feeds it decode/MEM info.
interface pipe_stall_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [5:0]       id_opcode;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic             mem_read;
  logic             mem_write;
  logic             dmem_ready;
  logic             pc_write;
  logic             ifid_write;
  logic             idex_write;
  logic             idex_bubble;
  logic             exmem_write;
  logic             memwb_bubble;
  logic             dmem_req;
  logic             err;
  logic [CNT_W-1:0] stall_count;

  modport master (
    input  id_opcode, id_rs, id_rt, ex_mem_read, ex_rt, mem_read, mem_write, dmem_ready,
    output pc_write, ifid_write, idex_write, idex_bubble, exmem_write, memwb_bubble,
    output dmem_req, err, stall_count
  );

  modport slave (
    output id_opcode, id_rs, id_rt, ex_mem_read, ex_rt, mem_read, mem_write, dmem_ready,
    input  pc_write, ifid_write, idex_write, idex_bubble, exmem_write, memwb_bubble,
    input  dmem_req, err, stall_count
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Stall/freeze sequencer: load-use bubbles, data-memory wait freeze, hung-memory trap.
// Optional saturating stall counter is built only when STALL_CNT_EN is defined.
module pipe_stall_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input logic               clk,
  input logic               rst,
  pipe_stall_ctrl_if.master bus
);

  localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

  localparam logic [5:0] OpRtype = 6'b000100;
  localparam logic [5:0] OpAddiu = 6'b001100;
  localparam logic [5:0] OpSubiu = 6'b001101;
  localparam logic [5:0] OpSw    = 6'b010000;
  localparam logic [5:0] OpLw    = 6'b010001;

  typedef enum logic [1:0] {StRun, StWait, StErr} state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             err_q, err_d;

  logic reads_rs, reads_rt, hazard, mem_op, freeze;
  logic pc_write_c;

  always_comb begin
    reads_rs = 1'b0;
    reads_rt = 1'b0;
    case (bus.id_opcode)
      OpRtype, OpSw: begin
        reads_rs = 1'b1;
        reads_rt = 1'b1;
      end
      OpAddiu, OpSubiu, OpLw: reads_rs = 1'b1;
      default: ;
    endcase
  end

  assign hazard = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
                  ((reads_rs && (bus.id_rs == bus.ex_rt)) ||
                   (reads_rt && (bus.id_rt == bus.ex_rt)));

  assign mem_op = bus.mem_read | bus.mem_write;

  always_comb begin
    state_d          = state_q;
    wait_d           = wait_q;
    err_d            = err_q;
    freeze           = 1'b0;
    pc_write_c       = 1'b1;
    bus.ifid_write   = 1'b1;
    bus.idex_write   = 1'b1;
    bus.idex_bubble  = 1'b0;
    bus.exmem_write  = 1'b1;
    bus.memwb_bubble = 1'b0;
    bus.dmem_req     = 1'b0;

    case (state_q)
      StRun: begin
        bus.dmem_req = mem_op;
        if (mem_op && !bus.dmem_ready) begin
          freeze  = 1'b1;
          state_d = StWait;
          wait_d  = '0;
        end
      end
      StWait: begin
        bus.dmem_req = 1'b1;
        if (bus.dmem_ready) begin
          state_d = StRun;
        end else begin
          freeze = 1'b1;
          if (wait_q == WaitLast) begin
            state_d = StErr;
            err_d   = 1'b1;
          end else begin
            wait_d = wait_q + WaitW'(1);
          end
        end
      end
      StErr: freeze = 1'b1;
      default: state_d = StRun;
    endcase

    // ID/EX is held during a freeze, so a pending load-use bubble must wait for RUN.
    if (freeze) begin
      pc_write_c       = 1'b0;
      bus.ifid_write   = 1'b0;
      bus.idex_write   = 1'b0;
      bus.exmem_write  = 1'b0;
      bus.memwb_bubble = 1'b1;
    end else if (hazard) begin
      pc_write_c      = 1'b0;
      bus.ifid_write  = 1'b0;
      bus.idex_bubble = 1'b1;
    end

    if (rst) begin
      pc_write_c       = 1'b1;
      bus.ifid_write   = 1'b1;
      bus.idex_write   = 1'b1;
      bus.idex_bubble  = 1'b0;
      bus.exmem_write  = 1'b1;
      bus.memwb_bubble = 1'b0;
      bus.dmem_req     = 1'b0;
    end
  end

  assign bus.pc_write = pc_write_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  assign bus.err = err_q;

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!pc_write_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.stall_count = cnt_q;
`else
  assign bus.stall_count = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: vector table for load-use decode, hand sequences
// for memory wait, timeout/ERR, freeze-vs-hazard and reset.
module tb_pipe_stall_ctrl;

  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned CNT_W   = 4;
  localparam int          CntMax  = (1 << CNT_W) - 1;

  localparam logic [5:0] OpR   = 6'h04;
  localparam logic [5:0] OpAdd = 6'h0C;
  localparam logic [5:0] OpSub = 6'h0D;
  localparam logic [5:0] OpSw  = 6'h10;
  localparam logic [5:0] OpLw  = 6'h11;
  localparam logic [5:0] OpOth = 6'h3F;

  // {pc_write, ifid_write, idex_write, idex_bubble, exmem_write, memwb_bubble, dmem_req}
  localparam logic [6:0] Go    = 7'b1110100;
  localparam logic [6:0] GoReq = 7'b1110101;
  localparam logic [6:0] Lu    = 7'b0011100;
  localparam logic [6:0] LuReq = 7'b0011101;
  localparam logic [6:0] FrzRq = 7'b0000011;
  localparam logic [6:0] FrzNo = 7'b0000010;

  typedef struct {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       exr;
    logic [4:0] exrt;
    logic       mr;
    logic       mw;
    logic       rdy;
    logic [6:0] exp;
    logic       err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_cnt = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic vec_t mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                              input logic exr, input logic [4:0] exrt, input logic mr,
                              input logic mw, input logic rdy, input logic [6:0] exp,
                              input logic err);
    vec_t v;
    v.op = op;  v.rs = rs;  v.rt = rt;  v.exr = exr;  v.exrt = exrt;
    v.mr = mr;  v.mw = mw;  v.rdy = rdy;  v.exp = exp;  v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {bus.pc_write, bus.ifid_write, bus.idex_write, bus.idex_bubble,
            bus.exmem_write, bus.memwb_bubble, bus.dmem_req};
  endfunction

  task automatic drive(input vec_t v);
    bus.id_opcode   = v.op;
    bus.id_rs       = v.rs;
    bus.id_rt       = v.rt;
    bus.ex_mem_read = v.exr;
    bus.ex_rt       = v.exrt;
    bus.mem_read    = v.mr;
    bus.mem_write   = v.mw;
    bus.dmem_ready  = v.rdy;
  endtask

  // One cycle: drive at negedge, check mid-cycle, advance the stall-count model.
  task automatic step(input string name, input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    chk({name, " outs"}, 32'(outs()), 32'(v.exp));
    chk({name, " stall_count"}, 32'(bus.stall_count), 32'(exp_cnt));
    chk({name, " err"}, 32'(bus.err), 32'(v.err));
`ifdef STALL_CNT_EN
    if (!v.exp[6] && exp_cnt != CntMax) exp_cnt++;
`endif
  endtask

  // Reset with a hazard and a miss on the inputs to show the outputs are forced.
  task automatic do_reset(input string name);
    @(negedge clk);
    rst = 1'b1;
    drive(mk(OpR, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, Go, 1'b0));
    #1;
    chk({name, " forced outs"}, 32'(outs()), 32'(Go));
    @(posedge clk);
    #1;
    chk({name, " outs"}, 32'(outs()), 32'(Go));
    chk({name, " stall_count"}, 32'(bus.stall_count), 32'd0);
    chk({name, " err"}, 32'(bus.err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(mk(OpOth, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, Go, 1'b0));
    exp_cnt = 0;
  endtask

  vec_t tbl[12];
  vec_t hz;
  vec_t idle;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(OpR,   5'd5,  5'd1,  1'b1, 5'd5,  1'b0, 1'b0, 1'b0, Lu,    1'b0);
    tbl[1]  = mk(OpR,   5'd1,  5'd2,  1'b1, 5'd5,  1'b0, 1'b0, 1'b0, Go,    1'b0);
    tbl[2]  = mk(OpAdd, 5'd0,  5'd3,  1'b1, 5'd0,  1'b0, 1'b0, 1'b0, Go,    1'b0);
    tbl[3]  = mk(OpAdd, 5'd3,  5'd7,  1'b1, 5'd7,  1'b0, 1'b0, 1'b0, Go,    1'b0);
    tbl[4]  = mk(OpR,   5'd2,  5'd7,  1'b1, 5'd7,  1'b0, 1'b0, 1'b0, Lu,    1'b0);
    tbl[5]  = mk(OpSw,  5'd1,  5'd9,  1'b1, 5'd9,  1'b0, 1'b0, 1'b0, Lu,    1'b0);
    tbl[6]  = mk(OpLw,  5'd1,  5'd9,  1'b1, 5'd9,  1'b0, 1'b0, 1'b0, Go,    1'b0);
    tbl[7]  = mk(OpSub, 5'd12, 5'd3,  1'b1, 5'd12, 1'b0, 1'b0, 1'b0, Lu,    1'b0);
    tbl[8]  = mk(OpOth, 5'd12, 5'd12, 1'b1, 5'd12, 1'b0, 1'b0, 1'b0, Go,    1'b0);
    tbl[9]  = mk(OpR,   5'd5,  5'd1,  1'b0, 5'd5,  1'b0, 1'b0, 1'b0, Go,    1'b0);
    tbl[10] = mk(OpR,   5'd1,  5'd2,  1'b0, 5'd0,  1'b1, 1'b0, 1'b1, GoReq, 1'b0);
    tbl[11] = mk(OpR,   5'd5,  5'd2,  1'b1, 5'd5,  1'b0, 1'b1, 1'b1, LuReq, 1'b0);

    idle = mk(OpOth, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, Go, 1'b0);
    drive(idle);

    do_reset("reset0");
    for (int i = 0; i < 12; i++) step($sformatf("vec%0d", i), tbl[i]);
    step("after_vectors", idle);

    // sw in MEM: 3 not-ready cycles, then release.
    do_reset("reset1");
    for (int i = 0; i < 3; i++)
      step($sformatf("sw_wait%0d", i), mk(OpOth, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0,
                                           FrzRq, 1'b0));
    step("sw_release", mk(OpOth, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, GoReq, 1'b0));
    step("sw_after", idle);
`ifdef STALL_CNT_EN
    chk("sw stall total", 32'(bus.stall_count), 32'd3);
`endif

    // Miss concurrent with a load-use pair: freeze holds ID/EX, bubble comes after RUN.
    do_reset("reset2");
    hz = mk(OpR, 5'd6, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, FrzRq, 1'b0);
    step("frz_hz0", hz);
    step("frz_hz1", hz);
    step("frz_release", mk(OpR, 5'd6, 5'd1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1, GoReq, 1'b0));
    step("frz_bubble", mk(OpR, 5'd6, 5'd1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, Lu, 1'b0));
    step("frz_clear", mk(OpR, 5'd6, 5'd1, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0, Go, 1'b0));

    // Hung lw: one RUN miss cycle, TIMEOUT WAIT cycles, then sticky ERR.
    do_reset("reset3");
    step("hang_run", mk(OpOth, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, FrzRq, 1'b0));
    for (int i = 0; i < int'(TIMEOUT); i++)
      step($sformatf("hang_wait%0d", i), mk(OpOth, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0,
                                             FrzRq, 1'b0));
    for (int i = 0; i < 3; i++)
      step($sformatf("err%0d", i), mk(OpOth, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0,
                                       FrzNo, 1'b1));
    for (int i = 0; i < 2; i++)
      step($sformatf("err_rdy%0d", i), mk(OpOth, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1,
                                           FrzNo, 1'b1));
`ifdef STALL_CNT_EN
    chk("saturated count", 32'(bus.stall_count), 32'(CntMax));
`endif
    do_reset("reset_from_err");
    step("post_err_idle", idle);
    step("post_err_access", mk(OpOth, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, GoReq, 1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
